// File: rtl/register_file_nbit.sv
// Multi-port register file with async clear and optional zeroed entry 0.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file_nbit #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                               clk,
  input  logic                               clr_n,
  input  logic                               we,
  input  logic [$clog2(DEPTH)-1:0]           waddr,
  input  logic [WIDTH-1:0]                   wdata,
  input  logic [READ_PORTS*$clog2(DEPTH)-1:0] raddr,
  output logic [READ_PORTS*WIDTH-1:0]        rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] entries;
  logic                        wInRange;

  assign wInRange = {1'b0, waddr} < (AW+1)'(DEPTH);

`ifdef REGFILE_BYPASS_EN
  logic wWritable;

  assign wWritable = wInRange &&
    !(ZERO_REG != 0 && waddr == '0);
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : gEntry
    if (ZERO_REG != 0 && i == 0) begin : gZero
      assign entries[i] = '0;
    end else begin : gFlop
      logic [WIDTH-1:0] q;
      logic             en;

      assign en = we && wInRange &&
        (waddr == AW'(i));

      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          q <= '0;
        end else if (en) begin
          q <= wdata;
        end
      end

      assign entries[i] = q;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : gRead
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    assign ra = raddr[p*AW +: AW];

    always_comb begin
      rd = '0;
      if ({1'b0, ra} < (AW+1)'(DEPTH)) begin
        rd = entries[ra];
      end
`ifdef REGFILE_BYPASS_EN
      // forwarding never beats a held-low clear
      if (clr_n && we && wWritable && waddr == ra) begin
        rd = wdata;
      end
`endif
    end

    assign rdata[p*WIDTH +: WIDTH] = rd;
  end

endmodule

// File: tb/tb_register_file_nbit.sv
// Randomised bench for register_file_nbit against an array model.
// Two instances: 24-entry/3-port/zeroed and 32-entry/2-port/plain.
module tb_register_file_nbit;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [14:0] raddrA = '0;
  logic [9:0]  raddrB = '0;
  logic [95:0] rdataA;
  logic [63:0] rdataB;

  logic [31:0] modelA [24];
  logic [31:0] modelB [32];
  logic [31:0] snapA [24];

  int passCnt = 0;
  int totalCnt = 0;
  bit run = 1'b0;

  register_file_nbit #(
    .WIDTH(32), .DEPTH(24), .READ_PORTS(3), .ZERO_REG(1)
  ) dutA (
    .clk(clk), .clr_n(clr_n), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddrA), .rdata(rdataA)
  );

  register_file_nbit #(
    .WIDTH(32), .DEPTH(32), .READ_PORTS(2), .ZERO_REG(0)
  ) dutB (
    .clk(clk), .clr_n(clr_n), .we(we), .waddr(waddr),
    .wdata(wdata), .raddr(raddrB), .rdata(rdataB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h, expected %h at %0t",
                  name, act, exp, $time);
  endtask

  function automatic logic [31:0] expRead(input bit isA, input int a);
    int depth;
    bit zero;
    logic [31:0] v;
    depth = isA ? 24 : 32;
    zero = isA;
    if (!clr_n || a >= depth || (zero && a == 0)) v = '0;
    else v = isA ? modelA[a] : modelB[a];
`ifdef REGFILE_BYPASS_EN
    if (clr_n && we && int'(waddr) == a && int'(waddr) < depth &&
        !(zero && waddr == 0)) v = wdata;
`endif
    return v;
  endfunction

  task automatic clearModels();
    foreach (modelA[i]) modelA[i] = '0;
    foreach (modelB[i]) modelB[i] = '0;
  endtask

  // advance one edge, committing to the model what the DUT saw there
  task automatic step();
    @(posedge clk);
    if (clr_n && we) begin
      if (waddr < 24 && waddr != 0) modelA[waddr] = wdata;
      modelB[waddr] = wdata;
    end
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    we = 1'b1;
    waddr = a[4:0];
    wdata = d;
    step();
    we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int p = 0; p < 3; p++)
        chk($sformatf("A.p%0d", p), rdataA[p*32 +: 32],
            expRead(1'b1, int'(raddrA[p*AW +: AW])));
      for (int p = 0; p < 2; p++)
        chk($sformatf("B.p%0d", p), rdataB[p*32 +: 32],
            expRead(1'b0, int'(raddrB[p*AW +: AW])));
    end
  end

  initial begin
    clearModels();
    run = 1'b1;
    step();
    chk("rst.A0", rdataA[31:0], 32'h0);
    chk("rst.B0", rdataB[31:0], 32'h0);
    step();
    clr_n = 1'b1;

    wr(5, 32'hDEADBEEF);
    raddrA = {5'd0, 5'd0, 5'd5};
    raddrB = {5'd0, 5'd5};
    #1;
    chk("pre.A5", rdataA[31:0], 32'hDEADBEEF);
    #1;
    clr_n = 1'b0;
    clearModels();
    #1;
    chk("arst.A5", rdataA[31:0], 32'h0);
    chk("arst.B5", rdataB[31:0], 32'h0);
    step();
    step();
    clr_n = 1'b1;

    raddrA = {5'd6, 5'd7, 5'd7};
    raddrB = {5'd8, 5'd7};
    wr(7, 32'h12345678);
    chk("wr.A7a", rdataA[31:0], 32'h12345678);
    chk("wr.A7b", rdataA[63:32], 32'h12345678);
    chk("wr.A6", rdataA[95:64], 32'h0);
    chk("wr.B8", rdataB[63:32], 32'h0);

    raddrA = '0;
    raddrB = '0;
    wr(0, 32'hFFFFFFFF);
    chk("zero.A", rdataA[31:0], 32'h0);
    chk("zero.B", rdataB[31:0], 32'hFFFFFFFF);

    foreach (snapA[i]) snapA[i] = modelA[i];
    wr(30, 32'hA5A5A5A5);
    for (int i = 0; i < 24; i++) begin
      raddrA[4:0] = i[4:0];
      #1;
      chk($sformatf("oor.scan%0d", i), rdataA[31:0], snapA[i]);
    end
    raddrA[4:0] = 5'd30;
    raddrB[4:0] = 5'd30;
    #1;
    chk("oor.A30", rdataA[31:0], 32'h0);
    chk("oor.B30", rdataB[31:0], 32'hA5A5A5A5);

    wr(3, 32'h11111111);
    raddrA[4:0] = 5'd3;
    we = 1'b1;
    waddr = 5'd3;
    wdata = 32'h22222222;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same.pre", rdataA[31:0], 32'h22222222);
`else
    chk("same.pre", rdataA[31:0], 32'h11111111);
`endif
    step();
    we = 1'b0;
    #1;
    chk("same.post", rdataA[31:0], 32'h22222222);

    wr(1, 32'h1);
    wr(2, 32'h2);
    wr(3, 32'h3);
    raddrA = {5'd2, 5'd1, 5'd3};
    #1;
    chk("mp.l0", rdataA[31:0], 32'h3);
    chk("mp.l1", rdataA[63:32], 32'h1);
    chk("mp.l2", rdataA[95:64], 32'h2);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(59) == 0) begin
        clr_n = 1'b0;
        clearModels();
      end else begin
        clr_n = 1'b1;
      end
      we = 1'($urandom_range(1));
      waddr = 5'($urandom_range(31));
      wdata = $urandom;
      for (int p = 0; p < 3; p++)
        raddrA[p*AW +: AW] = ($urandom_range(3) == 0) ?
          waddr : 5'($urandom_range(31));
      for (int p = 0; p < 2; p++)
        raddrB[p*AW +: AW] = ($urandom_range(3) == 0) ?
          waddr : 5'($urandom_range(31));
      step();
    end

    run = 1'b0;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
